// File: rtl/grad_batch_accumulator.sv
// Minibatch gradient accumulator: sums NUM_ELEM-element gradient samples over
// 2^BATCH_LOG2 samples, then drains the floor-averaged, saturated result in index order.
module grad_batch_accumulator #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 24,
    parameter int NUM_ELEM   = 24,
    parameter int BATCH_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(NUM_ELEM)-1:0] out_idx,
    output logic                        out_last,
    output logic [BATCH_LOG2:0]         sample_cnt
);

    localparam int IDX_W = $clog2(NUM_ELEM);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_ELEM - 1);
    localparam logic [BATCH_LOG2:0]   LAST_SAMPLE = (BATCH_LOG2 + 1)'((1 << BATCH_LOG2) - 1);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         elem_idx;
    logic signed [ACC_W-1:0]  acc [NUM_ELEM];

    // Saturating accumulate: one guard bit exposes overflow of the ACC_W-bit sum.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] d);
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W + 1 - DATA_W){d[DATA_W-1]}}, d};
        if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum[ACC_W-1:0];
    endfunction

    // Floor average, then clamp to DATA_W when the discarded high bits are not pure sign.
    function automatic logic [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0]  shifted;
        logic [ACC_W-DATA_W:0]    hi;
        shifted = a >>> BATCH_LOG2;
        hi      = shifted[ACC_W-1:DATA_W-1];
        if (&hi || ~|hi)
            return shifted[DATA_W-1:0];
        return shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? sat_out(acc[out_idx]) : '0;
    assign out_last  = out_valid && (out_idx == LAST_IDX);

    // NOTE: the accumulator array lives in flops with async reset because reset must
    // zero every element; a RAM without reset would leak a stale batch into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            elem_idx   <= '0;
            out_idx    <= '0;
            sample_cnt <= '0;
            for (int i = 0; i < NUM_ELEM; i++) acc[i] <= '0;
        end else if (clear) begin
            state      <= ACCUM;
            elem_idx   <= '0;
            out_idx    <= '0;
            sample_cnt <= '0;
            for (int i = 0; i < NUM_ELEM; i++) acc[i] <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc[elem_idx] <= sat_acc(acc[elem_idx], in_data);
                        if (elem_idx == LAST_IDX) begin
                            elem_idx   <= '0;
                            sample_cnt <= sample_cnt + 1'b1;
                            if (sample_cnt == LAST_SAMPLE) state <= DRAIN;
                        end else begin
                            elem_idx <= elem_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        acc[out_idx] <= '0;
                        if (out_idx == LAST_IDX) begin
                            out_idx    <= '0;
                            sample_cnt <= '0;
                            state      <= ACCUM;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_grad_batch_accumulator.sv
// Randomized bench: two accumulators (wide and narrow ACC_W) share one stimulus stream
// and are compared against an arithmetic model of the batch average.
module tb_grad_batch_accumulator;

    localparam int DATA_W = 16;
    localparam int NE     = 6;
    localparam int BL2    = 2;
    localparam int BATCH  = 1 << BL2;
    localparam int ACC_A  = 24;
    localparam int ACC_B  = 16;
    localparam int IDX_W  = $clog2(NE);

    logic clk, rst_n, clear, in_valid, out_ready;
    logic [DATA_W-1:0] in_data;

    logic              in_ready_a, out_valid_a, out_last_a;
    logic [DATA_W-1:0] out_data_a;
    logic [IDX_W-1:0]  out_idx_a;
    logic [BL2:0]      sample_cnt_a;
    logic              in_ready_b, out_valid_b, out_last_b;
    logic [DATA_W-1:0] out_data_b;
    logic [IDX_W-1:0]  out_idx_b;
    logic [BL2:0]      sample_cnt_b;

    int checks = 0;
    int errors = 0;

    longint m_acc_a [NE];
    longint m_acc_b [NE];
    int     m_elem;
    int     vals [NE*BATCH];

    grad_batch_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_A), .NUM_ELEM(NE), .BATCH_LOG2(BL2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_last(out_last_a), .sample_cnt(sample_cnt_a));

    grad_batch_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_B), .NUM_ELEM(NE), .BATCH_LOG2(BL2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_idx(out_idx_b), .out_last(out_last_b), .sample_cnt(sample_cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint clamp(input longint v, input int w);
        longint lo, hi;
        lo = -(64'sd1 <<< (w - 1));
        hi = (64'sd1 <<< (w - 1)) - 1;
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Batch mean rounded toward minus infinity, then clamped to the output range.
    function automatic longint expect_out(input longint acc);
        longint q;
        q = acc / BATCH;
        if (acc < 0 && (acc % BATCH) != 0) q = q - 1;
        return clamp(q, DATA_W);
    endfunction

    task automatic model_zero();
        for (int i = 0; i < NE; i++) begin
            m_acc_a[i] = 0;
            m_acc_b[i] = 0;
        end
        m_elem = 0;
    endtask

    task automatic fill_random(input int amp);
        for (int k = 0; k < NE*BATCH; k++) vals[k] = int'($urandom_range(0, 2*amp)) - amp;
    endtask

    task automatic send_elem(input int v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        while (in_ready_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready_a);
        end else begin
            @(posedge clk);
            m_acc_a[m_elem] = clamp(m_acc_a[m_elem] + v, ACC_A);
            m_acc_b[m_elem] = clamp(m_acc_b[m_elem] + v, ACC_B);
            m_elem = (m_elem + 1) % NE;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic feed_batch();
        for (int s = 0; s < BATCH; s++) begin
            for (int e = 0; e < NE; e++) begin
                if (s == BATCH-1 && e == NE-1) begin
                    checks++;
                    if (out_valid_a !== 1'b0) begin
                        errors++;
                        $display("FAIL early_out_valid: got %b, required 0", out_valid_a);
                    end
                end
                send_elem(vals[s*NE+e]);
            end
            checks++;
            if (sample_cnt_a !== 3'(s + 1) || sample_cnt_b !== 3'(s + 1)) begin
                errors++;
                $display("FAIL sample_cnt: got %0d/%0d, required %0d", sample_cnt_a, sample_cnt_b, s + 1);
            end
        end
        checks++;
        if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry: out_valid=%b in_ready=%b, required 1/0", out_valid_a, in_ready_a);
        end
    endtask

    // Drains n_elem elements; a full drain also checks the return to ACCUM.
    task automatic drain_batch(input int n_elem, input int stall_idx, input int stall_len, input bit rand_stall);
        for (int i = 0; i < n_elem; i++) begin
            int n = 0;
            int st;
            longint ea, eb;
            while (out_valid_a !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: idx %0d never presented", i);
                return;
            end
            ea = expect_out(m_acc_a[i]);
            eb = expect_out(m_acc_b[i]);
            checks++;
            if (out_idx_a !== IDX_W'(i)) begin
                errors++;
                $display("FAIL out_idx: got %0d, required %0d", out_idx_a, i);
            end
            checks++;
            if (longint'($signed(out_data_a)) != ea) begin
                errors++;
                $display("FAIL out_data_a[%0d]: got %0d, required %0d", i, $signed(out_data_a), ea);
            end
            checks++;
            if (longint'($signed(out_data_b)) != eb) begin
                errors++;
                $display("FAIL out_data_b[%0d]: got %0d, required %0d", i, $signed(out_data_b), eb);
            end
            checks++;
            if (out_last_a !== (i == NE-1) || out_last_b !== (i == NE-1)) begin
                errors++;
                $display("FAIL out_last[%0d]: got %b/%b, required %b", i, out_last_a, out_last_b, i == NE-1);
            end
            checks++;
            if (in_ready_a !== 1'b0 || out_valid_b !== 1'b1 || out_idx_b !== IDX_W'(i)) begin
                errors++;
                $display("FAIL drain_ctrl[%0d]: in_ready=%b valid_b=%b idx_b=%0d", i, in_ready_a, out_valid_b, out_idx_b);
            end
            st = (i == stall_idx) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            for (int k = 0; k < st; k++) begin
                out_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (out_valid_a !== 1'b1 || out_idx_a !== IDX_W'(i) || in_ready_a !== 1'b0 ||
                    longint'($signed(out_data_a)) != ea) begin
                    errors++;
                    $display("FAIL hold[%0d]: valid=%b idx=%0d data=%0d in_ready=%b, required 1/%0d/%0d/0",
                             i, out_valid_a, out_idx_a, $signed(out_data_a), in_ready_a, i, ea);
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            m_acc_a[i] = 0;
            m_acc_b[i] = 0;
            @(negedge clk);
            out_ready = 1'b0;
        end
        if (n_elem == NE) begin
            checks++;
            if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || sample_cnt_a !== '0 || in_ready_b !== 1'b1) begin
                errors++;
                $display("FAIL drain_exit: in_ready=%b out_valid=%b sample_cnt=%0d, required 1/0/0",
                         in_ready_a, out_valid_a, sample_cnt_a);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== '0 || out_idx_a !== '0 ||
            out_last_a !== 1'b0 || sample_cnt_a !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%0d idx=%0d last=%b cnt=%0d, required 1/0/0/0/0/0",
                     in_ready_a, out_valid_a, out_data_a, out_idx_a, out_last_a, sample_cnt_a);
        end
    endtask

    task automatic test_basic();
        fill_random(1000);
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
    endtask

    task automatic test_floor();
        int f0 [4] = '{-3, -5, 5, -4};
        int f1 [4] = '{0, -2, 0, 0};
        for (int k = 0; k < NE*BATCH; k++) vals[k] = 0;
        for (int e = 0; e < 4; e++) begin
            vals[e]      = f0[e];
            vals[NE + e] = f1[e];
        end
        vals[4] = -1;
        vals[5] = 7;
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NE*BATCH; k++) vals[k] = 32767;
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
        for (int k = 0; k < NE*BATCH; k++) vals[k] = -32768;
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        fill_random(20000);
        feed_batch();
        drain_batch(NE, 2, 5, 1'b0);
        test_basic();
    endtask

    task automatic test_clear();
        fill_random(5000);
        feed_batch();
        drain_batch(2, -1, 0, 1'b0);
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        model_zero();
        checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || sample_cnt_a !== '0 || out_idx_a !== '0) begin
            errors++;
            $display("FAIL clear_drain: vld=%b rdy=%b cnt=%0d idx=%0d, required 0/1/0/0",
                     out_valid_a, in_ready_a, sample_cnt_a, out_idx_a);
        end
        for (int k = 0; k < NE*BATCH; k++) vals[k] = 2;
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
        // clear in ACCUM, colliding with an input handshake that must be dropped
        for (int e = 0; e < 3; e++) send_elem(int'($urandom_range(0, 200)) - 100);
        in_valid = 1'b1; in_data = DATA_W'(1000); clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        model_zero();
        checks++;
        if (sample_cnt_a !== '0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_accum: cnt=%0d rdy=%b, required 0/1", sample_cnt_a, in_ready_a);
        end
        fill_random(3000);
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        fill_random(500);
        for (int e = 0; e < NE + 2; e++) send_elem(vals[e]);
        checks++;
        if (sample_cnt_a !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset_cnt: got %0d, required 1", sample_cnt_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample_cnt_a !== '0 || out_valid_a !== 1'b0 || out_idx_a !== '0 || out_data_a !== '0 ||
            out_last_a !== 1'b0 || sample_cnt_b !== '0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d vld=%b idx=%0d data=%0d last=%b, required 0/0/0/0/0",
                     sample_cnt_a, out_valid_a, out_idx_a, out_data_a, out_last_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b, required 1", in_ready_a);
        end
        fill_random(8000);
        feed_batch();
        drain_batch(NE, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            fill_random(32767);
            feed_batch();
            drain_batch(NE, -1, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_saturation();
        test_back_pressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/grad_batch_accumulator.md
Name: grad_batch_accumulator

Overview:
- Upstream of the parameter update stage.
- Accepts per-sample gradient elements (dW1..db3 flattened into one stream), accumulates them over a minibatch of 2^BATCH_LOG2 samples, then drains the batch-averaged gradients element by element.
- The drained stream feeds the update stage's dx inputs.
- Single clock; valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, signed fixed-point width of input and output gradient elements (matches data_type).
- ACC_W, 24, signed accumulator width; must be at least DATA_W+BATCH_LOG2.
- NUM_ELEM, 24, gradient elements per sample.
- BATCH_LOG2, 2, log2 of minibatch size (batch = 4).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: zero all accumulators and counters.
- in_valid  input  1  in_data holds a gradient element.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_W  signed gradient element, in element order 0..NUM_ELEM-1.
- out_valid  output  1  out_data holds an averaged gradient.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATA_W  signed batch-averaged gradient.
- out_idx  output  clog2(NUM_ELEM)  element index of out_data.
- out_last  output  1  high with the final element (idx NUM_ELEM-1) of a drain.
- sample_cnt  output  BATCH_LOG2+1  samples fully accumulated in the current batch.

Behaviour:
- Reset (rst_n low, async):
  - all accumulators, elem_idx and sample_cnt are 0; state is ACCUM.
  - in_ready=1 once reset releases; out_valid=0, out_data=0, out_idx=0, out_last=0.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: acc[elem_idx] <= sat_ACC(acc[elem_idx] + sext(in_data)).
  - elem_idx increments; at NUM_ELEM-1 it wraps to 0 and sample_cnt increments.
  - When that wrap brings sample_cnt to 2^BATCH_LOG2, the next state is DRAIN.
- State DRAIN:
  - in_ready=0; out_valid=1 from the first cycle after the last input handshake (1-cycle latency).
  - out_data = sat_DATA(acc[out_idx] >>> BATCH_LOG2): arithmetic shift (floor toward -inf), then saturate to the DATA_W signed range.
  - out_last = (out_idx==NUM_ELEM-1).
  - On out_valid&&out_ready: acc[out_idx] <= 0 and out_idx increments.
  - On the last handshake: out_idx=0, sample_cnt=0, return to ACCUM; in_ready=1 the following cycle.
  - With out_ready low, out_data and out_idx hold stable.
- Saturation:
  - Accumulator sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Output clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - No wrap-around in either case.
- clear (sync):
  - Highest priority: overrides any handshake in the same cycle; that handshake does not take effect.
  - Zeroes accumulators, elem_idx, out_idx and sample_cnt; state becomes ACCUM.
  - Valid in either state, including mid-drain.
- Reset mid-operation: async, immediately returns to reset values; no partial drain is resumed.
- Drain ordering: elements leave strictly in index order 0..NUM_ELEM-1, exactly once per batch.
- Inputs are never lost: in_ready is 0 throughout DRAIN, so upstream back-pressures.

Test Plan:
- NUM_ELEM=4, BATCH_LOG2=1; feed samples {8,-8,3,100} and {8,-8,4,-100} → out_data 8,-8,3,0 with out_idx 0..3; out_last only on idx 3; one cycle from last input to out_valid.
- Odd negative floor: samples {-3} and {0} at element 0 → out_data = -2 (-3>>>1).
- Saturation: DATA_W=16, BATCH_LOG2=2, four samples of 32767 → acc 131068, out_data 32767. With ACC_W=16, acc clamps at 32767 and out_data is 8191.
- Back-pressure: hold out_ready low 5 cycles during drain → out_data/out_idx stable and in_ready=0. Release → drain completes, then next batch accumulates from zero.
- clear mid-drain after idx 1 → next cycle out_valid=0, in_ready=1, sample_cnt=0. A new batch of all 2s outputs 2s, with no residue from the flushed batch.
- Assert rst_n low asynchronously mid-ACCUM (sample_cnt=1) → outputs immediately return to reset values; a subsequent full batch produces correct averages.
